// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port async SRAM controller that arbitrates between
// video scanout reads, MCU byte writes and a background refresh of the MCU
// read-back byte. Strobes are decoded from the registered state; address and
// write data come straight from flops so the pins are glitch-free while a
// cycle is in progress.
module vram_arbiter #(
  parameter int READ_WAIT_CYCLES   = 1,
  parameter int WRITE_PULSE_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        videoReadRequest,
  input  logic [16:0] videoReadAddress,
  output logic [7:0]  videoReadData,
  output logic        videoReadValid,
  output logic        videoReadOverrun,
  input  logic        mcuWriteRequest,
  input  logic [16:0] mcuWriteAddress,
  input  logic [7:0]  mcuWriteData,
  output logic        mcuWriteComplete,
  input  logic [16:0] mcuReadAddress,
  output logic [7:0]  mcuReadData,
  output logic [16:0] sramAddress,
  output logic [7:0]  sramDataOut,
  input  logic [7:0]  sramDataIn,
  output logic        sramDataOutEnable,
  output logic        sramChipEnable_n,
  output logic        sramOutputEnable_n,
  output logic        sramWriteEnable_n
);

  // The same down-counter times both the read wait and the write pulse.
  localparam int CNT_MAX = (READ_WAIT_CYCLES > WRITE_PULSE_CYCLES - 1) ?
                           READ_WAIT_CYCLES : WRITE_PULSE_CYCLES - 1;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT_CYCLES);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE_SETUP,
    S_WRITE_PULSE,
    S_WRITE_HOLD,
    S_WRITE_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_video_q, rd_video_d;
  logic               pend_q, pend_d;
  logic [16:0]        pend_addr_q, pend_addr_d;
  logic [16:0]        addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         vdata_q, vdata_d;
  logic               vvalid_q, vvalid_d;
  logic               overrun_q, overrun_d;
  logic [7:0]         mdata_q, mdata_d;

  logic               pend_take;
  logic               direct_video;

  // Control and pin-facing registers, all returned to their idle values on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rd_video_q <= 1'b0;
      pend_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      vdata_q    <= '0;
      vvalid_q   <= 1'b0;
      overrun_q  <= 1'b0;
      mdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_video_q <= rd_video_d;
      pend_q     <= pend_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      vdata_q    <= vdata_d;
      vvalid_q   <= vvalid_d;
      overrun_q  <= overrun_d;
      mdata_q    <= mdata_d;
    end
  end

  // Pending video address is only meaningful while pend_q is set, so it needs no reset.
  always_ff @(posedge clock) begin
    pend_addr_q <= pend_addr_d;
  end

  // Next-state: pending-request bookkeeping, IDLE arbitration and cycle timing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_video_d  = rd_video_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    vdata_d     = vdata_q;
    vvalid_d    = 1'b0;
    overrun_d   = 1'b0;
    mdata_d     = mdata_q;

    // A pending request is consumed by IDLE; a fresh request in an IDLE with
    // nothing pending goes straight to READ and is never latched.
    pend_take    = (state_q == S_IDLE) && pend_q;
    direct_video = (state_q == S_IDLE) && !pend_q && videoReadRequest;

    if (pend_take) begin
      pend_d = 1'b0;
    end
    if (videoReadRequest) begin
      pend_addr_d = videoReadAddress;
      if (!direct_video) begin
        pend_d = 1'b1;
      end
      if (pend_q && !pend_take) begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d    = S_READ;
          addr_d     = pend_addr_q;
          rd_video_d = 1'b1;
          cnt_d      = RD_LOAD;
        end else if (videoReadRequest) begin
          state_d    = S_READ;
          addr_d     = videoReadAddress;
          rd_video_d = 1'b1;
          cnt_d      = RD_LOAD;
        end else if (mcuWriteRequest) begin
          state_d = S_WRITE_SETUP;
          addr_d  = mcuWriteAddress;
          wdata_d = mcuWriteData;
        end else begin
          state_d    = S_READ;
          addr_d     = mcuReadAddress;
          rd_video_d = 1'b0;
          cnt_d      = RD_LOAD;
        end
      end
      S_READ: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (rd_video_q) begin
            vdata_d  = sramDataIn;
            vvalid_d = 1'b1;
          end else begin
            mdata_d = sramDataIn;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WRITE_SETUP: begin
        state_d = S_WRITE_PULSE;
        cnt_d   = WR_LOAD;
      end
      S_WRITE_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_WRITE_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WRITE_HOLD: begin
        state_d = S_WRITE_DONE;
      end
      S_WRITE_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobe decode: OE and WE are never low together, and the pad only drives during writes.
  always_comb begin
    sramChipEnable_n   = 1'b1;
    sramOutputEnable_n = 1'b1;
    sramWriteEnable_n  = 1'b1;
    sramDataOutEnable  = 1'b0;
    mcuWriteComplete   = 1'b0;
    case (state_q)
      S_READ: begin
        sramChipEnable_n   = 1'b0;
        sramOutputEnable_n = 1'b0;
      end
      S_WRITE_SETUP: begin
        sramChipEnable_n  = 1'b0;
        sramDataOutEnable = 1'b1;
      end
      S_WRITE_PULSE: begin
        sramChipEnable_n  = 1'b0;
        sramWriteEnable_n = 1'b0;
        sramDataOutEnable = 1'b1;
      end
      S_WRITE_HOLD: begin
        sramChipEnable_n  = 1'b0;
        sramDataOutEnable = 1'b1;
        mcuWriteComplete  = 1'b1;
      end
      default: begin
        sramChipEnable_n = 1'b1;
      end
    endcase
  end

  assign sramAddress      = addr_q;
  assign sramDataOut      = wdata_q;
  assign videoReadData    = vdata_q;
  assign videoReadValid   = vvalid_q;
  assign videoReadOverrun = overrun_q;
  assign mcuReadData      = mdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter. A timeline reference model turns each
// arbitration decision into the windows of cycles during which the SRAM pins
// must show a given pattern and the cycles at which result pulses appear.
module tb_vram_arbiter;

  localparam int R    = 1;
  localparam int WP   = 2;
  localparam int NCYC = 6000;
  localparam int NEV  = NCYC + 32;

  logic        clk;
  logic        reset;
  logic        vreq;
  logic [16:0] vaddr;
  logic [7:0]  vdata;
  logic        vvalid;
  logic        vovr;
  logic        wreq;
  logic [16:0] waddr;
  logic [7:0]  wdata;
  logic        wcmp;
  logic [16:0] raddr;
  logic [7:0]  rdata;
  logic [16:0] sa;
  logic [7:0]  sdo;
  logic [7:0]  sdi;
  logic        sdoe;
  logic        ce_n;
  logic        oe_n;
  logic        we_n;

  logic [7:0]  sram_mem [0:131071];
  logic [7:0]  ref_mem  [0:131071];
  logic [7:0]  junk;

  vram_arbiter #(.READ_WAIT_CYCLES(R), .WRITE_PULSE_CYCLES(WP)) dut (
    .clock              (clk),
    .reset              (reset),
    .videoReadRequest   (vreq),
    .videoReadAddress   (vaddr),
    .videoReadData      (vdata),
    .videoReadValid     (vvalid),
    .videoReadOverrun   (vovr),
    .mcuWriteRequest    (wreq),
    .mcuWriteAddress    (waddr),
    .mcuWriteData       (wdata),
    .mcuWriteComplete   (wcmp),
    .mcuReadAddress     (raddr),
    .mcuReadData        (rdata),
    .sramAddress        (sa),
    .sramDataOut        (sdo),
    .sramDataIn         (sdi),
    .sramDataOutEnable  (sdoe),
    .sramChipEnable_n   (ce_n),
    .sramOutputEnable_n (oe_n),
    .sramWriteEnable_n  (we_n)
  );

  // Async SRAM read path: data only when selected and output-enabled.
  assign sdi = (!ce_n && !oe_n) ? sram_mem[sa] : junk;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Expected timeline
  bit          ev_vvalid [NEV];
  bit          ev_ovr    [NEV];
  bit          ev_cmp    [NEV];
  bit          ev_vset   [NEV];
  bit          ev_mset   [NEV];
  logic [7:0]  ev_vdat   [NEV];
  logic [7:0]  ev_mdat   [NEV];
  bit          e_ce      [NEV];
  bit          e_oe      [NEV];
  bit          e_we      [NEV];
  bit          e_doe     [NEV];
  logic [16:0] e_sa      [NEV];
  logic [7:0]  e_sd      [NEV];

  int          free_at;
  bit          pend;
  logic [16:0] paddr;
  logic [7:0]  exp_vdata;
  logic [7:0]  exp_mdata;

  int          cyc;
  int          nerr;
  int          nchk;

  bit          wr_active;
  bit          wr_cool;
  int          rst_cnt;
  bit          prev_rst;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [16:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 17'($urandom_range(0, 31));
    else if (r == 7) return 17'h1FFFF;
    else return 17'($urandom);
  endfunction

  task automatic clear_slot(input int t);
    ev_vvalid[t] = 0; ev_ovr[t] = 0; ev_cmp[t] = 0;
    ev_vset[t] = 0; ev_mset[t] = 0;
    e_ce[t] = 1; e_oe[t] = 1; e_we[t] = 1; e_doe[t] = 0;
  endtask

  task automatic sched_read(input int c, input logic [16:0] a, input bit video);
    for (int t = c + 1; t <= c + R + 1; t++) begin
      e_ce[t] = 0; e_oe[t] = 0; e_sa[t] = a;
    end
    if (video) begin
      ev_vvalid[c + R + 2] = 1;
      ev_vset[c + R + 2]   = 1;
      ev_vdat[c + R + 2]   = ref_mem[a];
    end else begin
      ev_mset[c + R + 2] = 1;
      ev_mdat[c + R + 2] = ref_mem[a];
    end
    free_at = c + R + 2;
  endtask

  task automatic sched_write(input int c, input logic [16:0] a, input logic [7:0] d);
    for (int t = c + 1; t <= c + WP + 2; t++) begin
      e_ce[t] = 0; e_doe[t] = 1; e_sa[t] = a; e_sd[t] = d;
      if (t >= c + 2 && t <= c + WP + 1) e_we[t] = 0;
    end
    ev_cmp[c + WP + 2] = 1;
    ref_mem[a] = d;
    free_at = c + WP + 4;
  endtask

  task automatic check_cycle(input int c);
    if (ev_vset[c]) exp_vdata = ev_vdat[c];
    if (ev_mset[c]) exp_mdata = ev_mdat[c];
    check_val("vvalid",   32'(vvalid), 32'(ev_vvalid[c]));
    check_val("vdata",    32'(vdata),  32'(exp_vdata));
    check_val("mcu_rdata",32'(rdata),  32'(exp_mdata));
    check_val("overrun",  32'(vovr),   32'(ev_ovr[c]));
    check_val("complete", 32'(wcmp),   32'(ev_cmp[c]));
    check_val("ce_n",     32'(ce_n),   32'(e_ce[c]));
    check_val("oe_n",     32'(oe_n),   32'(e_oe[c]));
    check_val("we_n",     32'(we_n),   32'(e_we[c]));
    check_val("dout_en",  32'(sdoe),   32'(e_doe[c]));
    check_val("we_oe_excl", 32'(!we_n && !oe_n), 32'(0));
    if (!e_ce[c]) check_val("sram_addr", 32'(sa), 32'(e_sa[c]));
    if (e_doe[c]) check_val("sram_dout", 32'(sdo), 32'(e_sd[c]));
    if (prev_rst) begin
      check_val("rst_addr", 32'(sa),  32'(0));
      check_val("rst_dout", 32'(sdo), 32'(0));
    end
  endtask

  task automatic drive_inputs(input int c);
    junk = 8'($urandom);
    if (rst_cnt > 0) begin
      reset = 1'b1;
      rst_cnt--;
    end else if (c >= 20 && $urandom_range(0, 299) == 0) begin
      reset   = 1'b1;
      rst_cnt = $urandom_range(0, 2);
    end else begin
      reset = 1'b0;
    end
    vreq = (!reset && !prev_rst && $urandom_range(0, 6) == 0);
    if (vreq) vaddr = pick_addr();
    if (wr_active) begin
      if (wcmp) begin
        wr_active = 1'b0;
        wr_cool   = 1'b1;
      end
    end else if (wr_cool) begin
      wreq    = 1'b0;
      wr_cool = 1'b0;
    end else if ($urandom_range(0, 9) == 0) begin
      wr_active = 1'b1;
      wreq      = 1'b1;
      waddr     = pick_addr();
      wdata     = 8'($urandom);
    end
    if ($urandom_range(0, 39) == 0) raddr = pick_addr();
  endtask

  task automatic model_step(input int c);
    if (reset) begin
      for (int t = c + 1; t < NEV && t <= c + 20; t++) clear_slot(t);
      ev_vset[c + 1] = 1; ev_vdat[c + 1] = 8'h00;
      ev_mset[c + 1] = 1; ev_mdat[c + 1] = 8'h00;
      free_at = c + 1;
      pend    = 1'b0;
    end else if (c == free_at) begin
      if (pend) begin
        sched_read(c, paddr, 1'b1);
        pend = 1'b0;
        if (vreq) begin
          pend  = 1'b1;
          paddr = vaddr;
        end
      end else if (vreq) begin
        sched_read(c, vaddr, 1'b1);
      end else if (wreq) begin
        sched_write(c, waddr, wdata);
      end else begin
        sched_read(c, raddr, 1'b0);
      end
    end else if (vreq) begin
      if (pend) ev_ovr[c + 1] = 1;
      pend  = 1'b1;
      paddr = vaddr;
    end
  endtask

  initial begin
    nerr = 0; nchk = 0; cyc = 0;
    reset = 1'b1; vreq = 1'b0; vaddr = '0; wreq = 1'b0; waddr = '0; wdata = '0;
    raddr = 17'h00010; junk = 8'h00;
    wr_active = 1'b0; wr_cool = 1'b0; rst_cnt = 3; prev_rst = 1'b0;
    pend = 1'b0; paddr = '0; free_at = 0; exp_vdata = 8'h00; exp_mdata = 8'h00;
    for (int i = 0; i < 131072; i++) begin
      sram_mem[i] = 8'($urandom);
      ref_mem[i]  = sram_mem[i];
    end
    sram_mem[17'h00010] = 8'hA5; ref_mem[17'h00010] = 8'hA5;
    sram_mem[17'h1FFFF] = 8'h3C; ref_mem[17'h1FFFF] = 8'h3C;
    for (int t = 0; t < NEV; t++) begin
      clear_slot(t);
      e_sa[t] = '0; e_sd[t] = '0; ev_vdat[t] = '0; ev_mdat[t] = '0;
    end

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cyc = c;
      if (c >= 1) begin
        check_cycle(c);
        if (!ce_n && !we_n && sdoe) sram_mem[sa] = sdo;
      end
      drive_inputs(c);
      model_step(c);
      prev_rst = reset;
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
